pmem_line_responder: RTL and testbench
======================================

// Module: pmem_line_responder
// PURPOSE
//  Responder side of the cache-line physical-memory handshake (pmem_read/pmem_write/pmem_resp).
//  Serves one 128-bit line read or write per request after a fixed, parameterised latency.
//  Sits below the cache controller as a synthesizable backing store.
//  Is the stand-in for main memory in cache-level benches.
// PARAMETERS
//  ADDR_WIDTH   16   byte address width of pmem_address
//  LINE_BITS    128  line width; OFFSET_BITS = $clog2(LINE_BITS/8) = 4
//  INDEX_BITS   6    lines in store = 2**INDEX_BITS (64)
//  LATENCY      8    cycles from request acceptance to pmem_resp; legal range >= 1
// PORTS
//  clk            in   1           clock, all state on rising edge
//  rst_n          in   1           asynchronous, active-low reset
//  pmem_read      in   1           line read request, held high by initiator until pmem_resp
//  pmem_write     in   1           line write request, held high by initiator until pmem_resp
//  pmem_address   in   ADDR_WIDTH  byte address; offset bits ignored
//  pmem_wdata     in   LINE_BITS   write line, sampled at acceptance
//  pmem_rdata     out  LINE_BITS   read line, valid while pmem_resp=1, held until next read completes
//  pmem_resp      out  1           one-cycle completion pulse
//  pmem_err       out  1           sticky protocol-error flag (see CONFIGURATION)
// BEHAVIOUR
//  FSM states: IDLE, BUSY, RESP. Reset -> IDLE, pmem_resp=0, pmem_rdata=0, pmem_err=0, counter=0.
//  Reset does not clear the line array; contents survive reset.
//  Unwritten lines read as X in simulation.
//  IDLE: leave IDLE if pmem_read|pmem_write is high. Cycle 0 is the first cycle a request is visible.
//   On that edge capture op, index = pmem_address[OFFSET_BITS +: INDEX_BITS], and wdata.
//   Next state: LATENCY==1 -> RESP; else -> BUSY with cnt = LATENCY-2.
//  BUSY: if cnt==0 -> RESP, else cnt--. Inputs are ignored; the captured request is authoritative.
//  RESP: pmem_resp=1 for exactly this one cycle, which is cycle LATENCY after acceptance. Next -> IDLE.
//  Write: array[index] <= captured wdata on the edge entering RESP.
//  Read: pmem_rdata <= array[index] on the edge entering RESP.
//  Read-after-write to the same line returns the new data.
//  The initiator drops its request on the edge that ends RESP. IDLE therefore sees the next request no earlier than the cycle after RESP.
//  Back-to-back requests complete every LATENCY+1 cycles.
//  Address upper bits above OFFSET_BITS+INDEX_BITS are ignored, so addresses alias/wrap modulo the store size.
//  Counter width is $clog2(LATENCY) (min 1). No other arithmetic.
//  Simultaneous pmem_read & pmem_write at acceptance: treated as a write, read ignored. Error condition.
//  Request dropped while BUSY: the operation still completes and pmem_resp still pulses. Error condition.
//  Reset asserted mid-operation: immediate return to IDLE with pmem_resp=0.
//   A pending write is discarded (array unchanged); pmem_rdata clears to 0.
// CONFIGURATION
//  PMEM_PROTOCOL_CHECK_EN defined:
//   pmem_err is set on the edge where either error condition is detected:
//    - read and write both high at acceptance;
//    - pmem_read|pmem_write low during any BUSY cycle.
//   It stays high until rst_n. Simulation also issues $error with the cycle and condition.
//  Undefined: pmem_err tied 0, no checking logic, no messages. Datapath behaviour is identical either way.
// TESTING
//  Write 128'hDEAD..BEEF to addr 16'h0040, then read 16'h004A.
//   -> resp at cycle 8 after each acceptance; rdata = 128'hDEAD..BEEF.
//  LATENCY=1: read request held.
//   -> pmem_resp high in the cycle right after acceptance, low the next; resp every 2 cycles while held.
//  Write addr 16'h0010, read addr 16'h0410 (INDEX_BITS=6 wrap) -> same data returned.
//  read=1 & write=1 with wdata=128'h1 at addr 0, then plain read at addr 0.
//   -> rdata=128'h1; pmem_err=1 only with PMEM_PROTOCOL_CHECK_EN.
//  Drop pmem_read at BUSY cycle 3 -> resp still pulses at cycle 8; pmem_err=1 when enabled.
//  Write in flight, rst_n low at cycle 4 -> resp never pulses, rdata=0.
//   A later read of that line returns the prior contents.

Source files
------------

// File: rtl/pmem_line_responder.sv
// -----------------------------------------------------------------------------
// pmem_line_responder
//
// Responder side of the cache-line physical-memory handshake. It accepts one
// line read or write at a time and completes it with a one-cycle pmem_resp
// pulse exactly LATENCY cycles after acceptance. It serves as a synthesizable
// backing store below a cache controller and as main memory in cache benches.
//
// Parameters
//   ADDR_WIDTH  byte address width of pmem_address
//   LINE_BITS   line width in bits (offset bits = $clog2(LINE_BITS/8))
//   INDEX_BITS  log2 of the number of lines held
//   LATENCY     cycles from acceptance to pmem_resp (>= 1)
//
// Ports
//   clk           in   clock, all state on the rising edge
//   rst_n         in   asynchronous active-low reset (line array is kept)
//   pmem_read     in   line read request, held until pmem_resp
//   pmem_write    in   line write request, held until pmem_resp
//   pmem_address  in   byte address; offset and upper bits are ignored
//   pmem_wdata    in   write line, sampled at acceptance
//   pmem_rdata    out  read line, held until the next read completes
//   pmem_resp     out  one-cycle completion pulse
//   pmem_err      out  sticky protocol-error flag
//
// Build option
//   PMEM_PROTOCOL_CHECK_EN  when defined, pmem_err flags read+write at
//                           acceptance and a request dropped while busy, and
//                           simulation reports each event with $error. When
//                           undefined, pmem_err is tied low. The datapath is
//                           identical in both builds.
// -----------------------------------------------------------------------------

`ifdef PMEM_PROTOCOL_CHECK_EN
// Simulation-only reporter for protocol violations seen by the responder.
module pmem_line_responder_chk (
    input  logic clk,
    input  logic rst_n,
    input  logic both_s,
    input  logic drop_s
);
    logic [31:0] cyc_r;

    // Cycle counter and violation messages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_r <= 32'd0;
        end else begin
            cyc_r <= cyc_r + 32'd1;
            if (both_s) begin
                $error("pmem_line_responder: cycle %0d read and write both high at acceptance", cyc_r);
            end
            if (drop_s) begin
                $error("pmem_line_responder: cycle %0d request dropped while busy", cyc_r);
            end
        end
    end
endmodule
`endif

module pmem_line_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_BITS  = 128,
    parameter int INDEX_BITS = 6,
    parameter int LATENCY    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pmem_read,
    input  logic                  pmem_write,
    input  logic [ADDR_WIDTH-1:0] pmem_address,
    input  logic [LINE_BITS-1:0]  pmem_wdata,
    output logic [LINE_BITS-1:0]  pmem_rdata,
    output logic                  pmem_resp,
    output logic                  pmem_err
);
    localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
    localparam int NUM_LINES   = 2 ** INDEX_BITS;
    localparam int CNT_W       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit LAT_ONE     = (LATENCY == 1);
    // BUSY lasts LATENCY-1 cycles; the counter counts down to zero over them.
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic                   op_wr_r;
    logic [INDEX_BITS-1:0]  idx_r;
    logic [LINE_BITS-1:0]   wdata_r;
    logic [LINE_BITS-1:0]   rdata_r;
    logic                   resp_r;
    logic [LINE_BITS-1:0]   mem_r [0:NUM_LINES-1];

    logic                   req_s;
    logic                   accept_s;
    logic                   enter_resp_s;
    logic                   cur_wr_s;
    logic [INDEX_BITS-1:0]  cur_idx_s;
    logic [LINE_BITS-1:0]   cur_wdata_s;
    logic                   mem_we_s;
    logic                   rd_en_s;
    logic                   unused_addr_s;

    assign req_s = pmem_read | pmem_write;
    // Offset and alias bits of the address do not select anything.
    assign unused_addr_s = ^pmem_address;

    // Next-state, counter and completion decode.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    accept_s = 1'b1;
                    if (LAT_ONE) begin
                        state_s      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_s = ST_BUSY;
                        cnt_s   = CNT_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // With LATENCY==1 the request completes on its acceptance edge, so the
    // live inputs stand in for the not-yet-captured request.
    always_comb begin
        cur_wr_s    = op_wr_r;
        cur_idx_s   = idx_r;
        cur_wdata_s = wdata_r;
        if (accept_s) begin
            cur_wr_s    = pmem_write;
            cur_idx_s   = pmem_address[OFFSET_BITS +: INDEX_BITS];
            cur_wdata_s = pmem_wdata;
        end else begin
            cur_wr_s    = op_wr_r;
            cur_idx_s   = idx_r;
            cur_wdata_s = wdata_r;
        end
        // Reset gating keeps a LATENCY==1 request from writing while held in reset.
        mem_we_s = enter_resp_s & cur_wr_s & rst_n;
        rd_en_s  = enter_resp_s & ~cur_wr_s;
    end

    // State, counter and request capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            op_wr_r <= 1'b0;
            idx_r   <= {INDEX_BITS{1'b0}};
            wdata_r <= {LINE_BITS{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                // A write wins when both request lines are high.
                op_wr_r <= pmem_write;
                idx_r   <= pmem_address[OFFSET_BITS +: INDEX_BITS];
                wdata_r <= pmem_wdata;
            end else begin
                op_wr_r <= op_wr_r;
                idx_r   <= idx_r;
                wdata_r <= wdata_r;
            end
        end
    end

    // Registered response pulse and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_r  <= 1'b0;
            rdata_r <= {LINE_BITS{1'b0}};
        end else begin
            resp_r <= enter_resp_s;
            if (rd_en_s) begin
                rdata_r <= mem_r[cur_idx_s];
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    // Line array; deliberately not reset so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[cur_idx_s] <= cur_wdata_s;
        end
    end

    assign pmem_resp  = resp_r;
    assign pmem_rdata = rdata_r;

`ifdef PMEM_PROTOCOL_CHECK_EN
    logic err_r;
    logic both_s;
    logic drop_s;

    assign both_s = accept_s & pmem_read & pmem_write;
    assign drop_s = (state_r == ST_BUSY) & ~req_s;

    // Sticky protocol error flag, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (both_s || drop_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign pmem_err = err_r;

`ifndef SYNTHESIS
    pmem_line_responder_chk u_chk (
        .clk    (clk),
        .rst_n  (rst_n),
        .both_s (both_s),
        .drop_s (drop_s)
    );
`endif
`else
    assign pmem_err = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// -----------------------------------------------------------------------------
// tb_pmem_line_responder
//
// Self-checking bench for pmem_line_responder. A LATENCY=8 instance carries the
// directed and random traffic; a LATENCY=1 instance checks the minimum-latency
// cadence. Expected data comes from a line-array model indexed by
// (address / 16) % 64, and expected timing from the fixed latency.
// -----------------------------------------------------------------------------
module tb_pmem_line_responder;
    localparam int LAT = 8;

    logic         clk;
    logic         rst_n;

    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp, pmem_err;

    logic         r1, w1;
    logic [15:0]  a1;
    logic [127:0] wd1, rdata1;
    logic         resp1, err1;

    int tests_run = 0;
    int tests_failed = 0;

    logic [127:0] model [0:63];
    bit           valid [0:63];
    logic [127:0] exp_rd;
    bit           rd_known;
    logic         err_exp;

    pmem_line_responder #(.ADDR_WIDTH(16), .LINE_BITS(128), .INDEX_BITS(6), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp), .pmem_err(pmem_err)
    );

    pmem_line_responder #(.ADDR_WIDTH(16), .LINE_BITS(128), .INDEX_BITS(6), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pmem_read(r1), .pmem_write(w1),
        .pmem_address(a1), .pmem_wdata(wd1), .pmem_rdata(rdata1),
        .pmem_resp(resp1), .pmem_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One complete request on the LATENCY=8 instance. drop_at>0 removes the
    // request so that it is low from that cycle on (counted from acceptance).
    task automatic xact(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [127:0] wd, input int drop_at);
        int idx;
        idx = (int'(addr) / 16) % 64;
        pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wd;
`ifdef PMEM_PROTOCOL_CHECK_EN
        if (rd && wr) err_exp = 1'b1;
        if (drop_at > 0 && drop_at < LAT) err_exp = 1'b1;
`endif
        if (wr) begin
            model[idx] = wd;
            valid[idx] = 1'b1;
        end else if (valid[idx]) begin
            exp_rd = model[idx];
            rd_known = 1'b1;
        end else begin
            rd_known = 1'b0;
        end
        for (int c = 0; c <= LAT; c++) begin
            @(negedge clk);
            chk("resp_timing", {127'd0, pmem_resp}, {127'd0, (c == LAT)});
            if (c == LAT) begin
                if (rd_known) chk("rdata", pmem_rdata, exp_rd);
                chk("err", {127'd0, pmem_err}, {127'd0, err_exp});
            end
            @(posedge clk); #1;
            if (c == LAT || c + 1 == drop_at) begin
                pmem_read = 1'b0; pmem_write = 1'b0;
            end else begin
                // Inputs are ignored while busy; scramble them.
                pmem_address = 16'($urandom());
                pmem_wdata = rand_line();
            end
        end
    endtask

    initial begin
        logic [127:0] beef, l10, x1;
        int up, ix, off, kind, drop, gap;
        logic [15:0] ra;

        for (int i = 0; i < 64; i++) valid[i] = 1'b0;
        rst_n = 1'b0;
        pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = 16'd0; pmem_wdata = 128'd0;
        r1 = 1'b0; w1 = 1'b0; a1 = 16'd0; wd1 = 128'd0;
        err_exp = 1'b0; exp_rd = 128'd0; rd_known = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp", {127'd0, pmem_resp}, 128'd0);
        chk("reset_rdata", pmem_rdata, 128'd0);
        chk("reset_err", {127'd0, pmem_err}, 128'd0);
        chk("reset_resp1", {127'd0, resp1}, 128'd0);
        chk("reset_rdata1", rdata1, 128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read with a different offset in the same line.
        beef = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
        xact(1'b0, 1'b1, 16'h0040, beef, 0);
        xact(1'b1, 1'b0, 16'h004A, 128'd0, 0);

        // Upper address bits alias onto the same line.
        l10 = rand_line();
        xact(1'b0, 1'b1, 16'h0010, l10, 0);
        xact(1'b1, 1'b0, 16'h0410, 128'd0, 0);

        // Read and write together is a write.
        xact(1'b1, 1'b1, 16'h0000, 128'h1, 0);
        xact(1'b1, 1'b0, 16'h0000, 128'd0, 0);

        // Request dropped in busy cycle 3 still completes.
        xact(1'b1, 1'b0, 16'h0040, 128'd0, 3);

        // Write in flight aborted by reset at cycle 4.
        pmem_write = 1'b1; pmem_address = 16'h0040; pmem_wdata = rand_line();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_resp_pre", {127'd0, pmem_resp}, 128'd0);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        pmem_write = 1'b0;
        #1;
        chk("abort_resp", {127'd0, pmem_resp}, 128'd0);
        chk("abort_rdata", pmem_rdata, 128'd0);
        for (int c = 4; c < LAT + 3; c++) begin
            @(negedge clk);
            chk("abort_no_resp", {127'd0, pmem_resp}, 128'd0);
            if (c == 6) rst_n = 1'b1;
        end
        err_exp = 1'b0; exp_rd = 128'd0; rd_known = 1'b1;
        @(posedge clk); #1;
        xact(1'b1, 1'b0, 16'h0040, 128'd0, 0);
        chk("abort_prior_data", pmem_rdata, beef);

        // Random traffic, back-to-back or with short gaps.
        for (int n = 0; n < 40; n++) begin
            up = $urandom_range(0, 63); ix = $urandom_range(0, 7); off = $urandom_range(0, 15);
            ra = 16'(up * 1024 + ix * 16 + off);
            kind = $urandom_range(0, 7);
            drop = ($urandom_range(0, 7) == 0) ? $urandom_range(1, LAT - 1) : 0;
            if (kind == 0)      xact(1'b1, 1'b1, ra, rand_line(), drop);
            else if (kind < 4)  xact(1'b0, 1'b1, ra, rand_line(), drop);
            else                xact(1'b1, 1'b0, ra, rand_line(), drop);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(negedge clk);
                chk("idle_no_resp", {127'd0, pmem_resp}, 128'd0);
                @(posedge clk); #1;
            end
        end

        // LATENCY=1 instance: write, then hold a read.
        x1 = rand_line();
        w1 = 1'b1; a1 = 16'h0020; wd1 = x1;
        @(negedge clk);
        chk("l1_wr_c0", {127'd0, resp1}, 128'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("l1_wr_c1", {127'd0, resp1}, 128'd1);
        @(posedge clk); #1;
        w1 = 1'b0; r1 = 1'b1; a1 = 16'hFC27;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("l1_rd_cadence", {127'd0, resp1}, {127'd0, (k % 2 == 1)});
            if (k % 2 == 1) chk("l1_rdata", rdata1, x1);
            @(posedge clk); #1;
        end
        r1 = 1'b0;
        @(negedge clk);
        chk("l1_err", {127'd0, err1}, 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
